uart_rx_ovs: RTL

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs_if.sv | 28 ++
 rtl/uart_rx_ovs.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs_if
// Description : Receive-side delivery bus of the oversampling UART receiver:
//               held byte, status flags and the valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ovs_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;

  // Receiver side: produces the byte and flags, observes ready.
  modport master (
    output data, valid, parity_error, frame_error, overrun,
    input  ready
  );

  // Consumer side.
  modport slave (
    input  data, valid, parity_error, frame_error, overrun,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs
// Description : UART receiver with 16x oversampling and 2-of-3 majority
//               voting at ticks 7/8/9. It supports 7/8 data bits, optional
//               odd/even/mark/space parity, and 1 or 2 stop bits. The
//               received byte is held until it is accepted, and a frame that
//               arrives while the byte is still held raises overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
  parameter int unsigned DIV = 54
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            data_size,
  input  logic            parity_en,
  input  logic [1:0]      parity_mode,
  input  logic            stop_bit_size,
  output logic            busy,
  uart_rx_ovs_if.master   bus
);

  localparam int unsigned      DIV_W   = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_idx_q, tick_idx_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic             cfg_size8_q, cfg_size8_d;
  logic             cfg_par_en_q, cfg_par_en_d;
  logic [1:0]       cfg_pmode_q, cfg_pmode_d;
  logic             cfg_stop2_q, cfg_stop2_d;
  logic             par_err_q, par_err_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             pe_out_q, pe_out_d;
  logic             fe_out_q, fe_out_d;
  logic             ovr_q, ovr_d;

  logic             tick;
  logic             maj;
  logic             start_edge;
  logic             frame_done;
  logic             final_fe;
  logic             par_exp;
  logic [7:0]       rx_byte;

  // The tick-9 sample is taken straight from the synchronizer output, so
  // the vote uses the two stored samples plus the live one.
  assign tick       = (div_cnt_q == DIV_MAX);
  assign maj        = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);
  assign start_edge = rx_prev_q & ~rx_s2_q;
  assign final_fe   = frame_err_q | ~maj;
  assign rx_byte    = cfg_size8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign busy       = (state_q != IDLE);

  // Expected parity bit for the latched mode, over the data bits only.
  always_comb begin
    par_exp = 1'b0;
    case (cfg_pmode_q)
      2'b11:   par_exp = ~^rx_byte;
      2'b10:   par_exp = ^rx_byte;
      2'b01:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  // Frame FSM: tick generation, bit timing, sampling and shifting.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    tick_idx_d   = tick_idx_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    cfg_size8_d  = cfg_size8_q;
    cfg_par_en_d = cfg_par_en_q;
    cfg_pmode_d  = cfg_pmode_q;
    cfg_stop2_d  = cfg_stop2_q;
    par_err_d    = par_err_q;
    frame_err_d  = frame_err_q;
    frame_done   = 1'b0;

    if (state_q == IDLE) begin
      // Counters stay cleared so tick 0 starts right at the start edge.
      div_cnt_d  = '0;
      tick_idx_d = '0;
      if (start_edge) begin
        state_d      = START;
        cfg_size8_d  = data_size;
        cfg_par_en_d = parity_en;
        cfg_pmode_d  = parity_mode;
        cfg_stop2_d  = stop_bit_size;
        bit_cnt_d    = '0;
        par_err_d    = 1'b0;
        frame_err_d  = 1'b0;
      end
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        tick_idx_d = tick_idx_q + 4'd1;
        if (tick_idx_q == 4'd7) s7_d = rx_s2_q;
        if (tick_idx_q == 4'd8) s8_d = rx_s2_q;

        // Tick 9: the bit value is now decided.
        if (tick_idx_q == 4'd9) begin
          case (state_q)
            START:   if (maj) state_d = IDLE;
            DATA:    shift_d = {maj, shift_q[7:1]};
            PARITY:  par_err_d = (maj != par_exp);
            STOP1: begin
              frame_err_d = final_fe;
              if (!cfg_stop2_q) begin
                frame_done = 1'b1;
                state_d    = IDLE;
              end
            end
            STOP2: begin
              frame_err_d = final_fe;
              frame_done  = 1'b1;
              state_d     = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end

        // Tick 15: last tick of the bit, move on to the next field.
        if (tick_idx_q == 4'd15) begin
          case (state_q)
            START:   state_d = DATA;
            DATA: begin
              if (bit_cnt_q == (cfg_size8_q ? 3'd7 : 3'd6)) begin
                state_d = cfg_par_en_q ? PARITY : STOP1;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
            PARITY:  state_d = STOP1;
            STOP1:   state_d = STOP2;
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Output holding register with overrun handling.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    pe_out_d = pe_out_q;
    fe_out_d = fe_out_q;
    ovr_d    = ovr_q;
    if (frame_done) begin
      if (valid_q && !bus.ready) begin
        // The consumer still holds the old byte: drop the new frame.
        ovr_d = 1'b1;
      end else begin
        data_d   = rx_byte;
        pe_out_d = par_err_q;
        fe_out_d = final_fe;
        valid_d  = 1'b1;
        ovr_d    = 1'b0;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State registers; synchronizer flops reset to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      tick_idx_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      cfg_size8_q  <= 1'b0;
      cfg_par_en_q <= 1'b0;
      cfg_pmode_q  <= '0;
      cfg_stop2_q  <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      pe_out_q     <= 1'b0;
      fe_out_q     <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      tick_idx_q   <= tick_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      cfg_size8_q  <= cfg_size8_d;
      cfg_par_en_q <= cfg_par_en_d;
      cfg_pmode_q  <= cfg_pmode_d;
      cfg_stop2_q  <= cfg_stop2_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      pe_out_q     <= pe_out_d;
      fe_out_q     <= fe_out_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.data         = data_q;
  assign bus.valid        = valid_q;
  assign bus.parity_error = pe_out_q;
  assign bus.frame_error  = fe_out_q;
  assign bus.overrun      = ovr_q;

endmodule
`default_nettype wire
